// File: rtl/nand_logic_pkg.sv
// Shared opcode definitions for the NAND-built logic pipeline.
package nand_logic_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND     = 3'd0;
    localparam op_t OP_OR      = 3'd1;
    localparam op_t OP_NAND    = 3'd2;
    localparam op_t OP_NOR     = 3'd3;
    localparam op_t OP_XOR     = 3'd4;
    localparam op_t OP_XNOR    = 3'd5;
    localparam op_t OP_NOT     = 3'd6;
    localparam op_t OP_ILLEGAL = 3'd7;

endpackage

// File: rtl/nand_gate_slice.sv
// Combinational slice producing all seven logic functions per bit,
// each built exclusively from 2-input NAND gates.
module nand_gate_slice #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_y,
    output logic [WIDTH-1:0] or_y,
    output logic [WIDTH-1:0] nand_y,
    output logic [WIDTH-1:0] nor_y,
    output logic [WIDTH-1:0] xor_y,
    output logic [WIDTH-1:0] xnor_y,
    output logic [WIDTH-1:0] not_y
);

    logic [WIDTH-1:0] na_s;   // NAND(a,a) = ~a
    logic [WIDTH-1:0] nb_s;   // NAND(b,b) = ~b
    logic [WIDTH-1:0] nab_s;  // NAND(a,b)
    logic [WIDTH-1:0] t1_s;   // NAND(a, nab)
    logic [WIDTH-1:0] t2_s;   // NAND(b, nab)

    assign na_s   = ~(a & a);
    assign nb_s   = ~(b & b);
    assign nab_s  = ~(a & b);
    assign t1_s   = ~(a & nab_s);
    assign t2_s   = ~(b & nab_s);

    assign not_y  = na_s;                 // 1 NAND
    assign nand_y = nab_s;                // 1 NAND
    assign and_y  = ~(nab_s & nab_s);     // 2 NANDs
    assign or_y   = ~(na_s & nb_s);       // 3 NANDs
    assign nor_y  = ~(or_y & or_y);       // 4 NANDs
    assign xor_y  = ~(t1_s & t2_s);       // classic 4-NAND XOR
    assign xnor_y = ~(xor_y & xor_y);     // 5 NANDs

endmodule

// File: rtl/nand_logic_pipe.sv
// Two-stage valid/ready logic pipeline: stage 1 evaluates the selected
// NAND-built function (optionally chained on the accumulator), stage 2
// registers the result with parity/zero/error flags toward the sink.
module nand_logic_pipe
    import nand_logic_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic               chain,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               parity,
    output logic               zero,
    output logic               err,
    output logic [COUNT_W-1:0] op_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic               ready_en_r;
    logic               s1_valid_r;
    logic [WIDTH-1:0]   s1_data_r;
    logic               s1_err_r;
    logic [WIDTH-1:0]   acc_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               parity_r;
    logic               zero_r;
    logic               err_r;
    logic [COUNT_W-1:0] op_count_r;

    logic [WIDTH-1:0]   a_eff_s;
    logic [WIDTH-1:0]   r1_s;
    logic               err1_s;
    logic               out_stall_s;
    logic               s2_ready_s;
    logic               accept_s;
    logic               transfer_s;
    logic               s1_adv_s;
    logic [WIDTH-1:0]   and_s, or_s, nand_s, nor_s, xor_s, xnor_s, not_s;

    assign out_stall_s = out_valid_r & ~out_ready;
    assign s2_ready_s  = ~out_stall_s;
    // ready_en_r keeps in_ready low until the first edge after reset release
    assign in_ready    = ready_en_r & (~s1_valid_r | s2_ready_s) & ~clr;
    assign accept_s    = in_valid & in_ready;
    assign transfer_s  = out_valid_r & out_ready;
    assign s1_adv_s    = s1_valid_r & s2_ready_s;
    assign a_eff_s     = chain ? acc_r : a;

    nand_gate_slice #(.WIDTH(WIDTH)) u_slice (
        .a      (a_eff_s),
        .b      (b),
        .and_y  (and_s),
        .or_y   (or_s),
        .nand_y (nand_s),
        .nor_y  (nor_s),
        .xor_y  (xor_s),
        .xnor_y (xnor_s),
        .not_y  (not_s)
    );

    // Select the stage-1 function output; opcode 7 yields zero with error
    always_comb begin
        r1_s   = '0;
        err1_s = 1'b0;
        case (op)
            OP_AND:  r1_s = and_s;
            OP_OR:   r1_s = or_s;
            OP_NAND: r1_s = nand_s;
            OP_NOR:  r1_s = nor_s;
            OP_XOR:  r1_s = xor_s;
            OP_XNOR: r1_s = xnor_s;
            OP_NOT:  r1_s = not_s;
            default: begin
                r1_s   = '0;
                err1_s = 1'b1;
            end
        endcase
    end

    // Input-enable flag: low in reset, high from the first clock after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Stage 1: capture accepted beat and update the chain accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_err_r   <= 1'b0;
            acc_r      <= '0;
        end else if (clr) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_err_r   <= 1'b0;
            acc_r      <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_data_r  <= r1_s;
            s1_err_r   <= err1_s;
            acc_r      <= r1_s;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: register result and flags; hold them while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            parity_r    <= 1'b0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
        end else if (clr) begin
            out_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            out_valid_r <= 1'b1;
            result_r    <= s1_data_r;
            parity_r    <= parity_f(s1_data_r);
            zero_r      <= (s1_data_r == '0);
            err_r       <= s1_err_r;
        end else if (transfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of completed output transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= '0;
        end else if (clr) begin
            op_count_r <= '0;
        end else if (transfer_s && (op_count_r != COUNT_MAX)) begin
            op_count_r <= op_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign parity    = parity_r;
    assign zero      = zero_r;
    assign err       = err_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_nand_logic_pipe.sv
// Scoreboard bench for nand_logic_pipe (WIDTH=8, COUNT_W=2).
module tb_nand_logic_pipe;

    localparam int W  = 8;
    localparam int CW = 2;
    localparam int CNT_MAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'd0;
    logic          chain = 1'b0;
    logic [W-1:0]  a = 8'h00;
    logic [W-1:0]  b = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          parity;
    logic          zero;
    logic          err;
    logic [CW-1:0] op_count;

    typedef struct packed {
        logic         err;
        logic         zero;
        logic         par;
        logic [W-1:0] res;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_acc = 8'h00;
    int           m_cnt = 0;
    int           checks = 0;
    int           errors = 0;

    nand_logic_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .chain(chain), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .parity(parity), .zero(zero), .err(err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference function using plain operators: returns {err, result}
    function automatic logic [W:0] model_f(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            3'd0: return {1'b0, x & y};
            3'd1: return {1'b0, x | y};
            3'd2: return {1'b0, ~(x & y)};
            3'd3: return {1'b0, ~(x | y)};
            3'd4: return {1'b0, x ^ y};
            3'd5: return {1'b0, ~(x ^ y)};
            3'd6: return {1'b0, ~x};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    // Present one beat and wait (bounded) for it to be accepted
    task automatic send(input logic [2:0] o, input logic ch, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        exp_t e;
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; op = o; chain = ch; a = x; b = y;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                r = model_f(o, ch ? m_acc : x, y);
                m_acc = r[W-1:0];
                e.err = r[W]; e.res = r[W-1:0]; e.par = ^r[W-1:0]; e.zero = (r[W-1:0] == 8'h00);
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; chain = 1'b0;
        if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: compare every completed transfer against the scoreboard
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("result", 32'(result), 32'(e.res));
                check_eq("parity", 32'(parity), 32'(e.par));
                check_eq("zero",   32'(zero),   32'(e.zero));
                check_eq("err",    32'(err),    32'(e.err));
            end
            if (m_cnt < CNT_MAX) m_cnt++;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result",    32'(result),    32'd0);
        check_eq("rst_flags",     32'({parity, zero, err}), 32'd0);
        check_eq("rst_op_count",  32'(op_count),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Single beat with latency check
        send(3'd0, 1'b0, 8'hF0, 8'hCC);
        @(negedge clk);
        check_eq("lat_s1_only", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_out_valid", 32'(out_valid), 32'd1);
        idle(2);
        check_eq("op_count_1", 32'(op_count), 32'd1);

        // Back-to-back beats
        send(3'd4, 1'b0, 8'hF0, 8'hCC);
        send(3'd3, 1'b0, 8'hF0, 8'hCC);
        send(3'd2, 1'b0, 8'hFF, 8'hFF);
        idle(4);

        // Chain sequence and illegal opcode
        send(3'd4, 1'b0, 8'hF0, 8'hCC);
        send(3'd0, 1'b1, 8'h55, 8'h0F);
        send(3'd6, 1'b1, 8'h55, 8'h00);
        send(3'd7, 1'b0, 8'hFF, 8'hFF);
        send(3'd1, 1'b1, 8'hA5, 8'h11);
        idle(4);
        check_eq("op_count_sat", 32'(op_count), 32'(m_cnt));
        check_eq("op_count_sat_val", 32'(op_count), 32'(CNT_MAX));

        // Synchronous clear
        clr = 1'b1;
        exp_q.delete(); m_acc = 8'h00; m_cnt = 0;
        @(negedge clk);
        check_eq("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        check_eq("clr_op_count",  32'(op_count),  32'd0);
        check_eq("clr_out_valid", 32'(out_valid), 32'd0);
        send(3'd1, 1'b1, 8'hEE, 8'h11);
        idle(4);
        check_eq("op_count_after_clr", 32'(op_count), 32'd1);

        // Backpressure: two beats fill the pipe, third must wait
        clr = 1'b1; exp_q.delete(); m_cnt = 0;
        @(posedge clk); #1;
        clr = 1'b0;
        out_ready = 1'b0;
        send(3'd0, 1'b0, 8'hF0, 8'hCC);
        send(3'd1, 1'b0, 8'hF0, 8'hCC);
        in_valid = 1'b1; op = 3'd5; chain = 1'b0; a = 8'hF0; b = 8'hCC;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready),  32'd0);
            check_eq("bp_hold",     32'(result),    32'h0000_00C0);
            check_eq("bp_valid",    32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd5, 1'b0, 8'hF0, 8'hCC);
        idle(5);
        check_eq("bp_op_count", 32'(op_count), 32'd3);

        // Reset asserted mid-stall
        out_ready = 1'b0;
        send(3'd2, 1'b0, 8'hFF, 8'h0F);
        idle(2);
        @(negedge clk);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_result",    32'(result),    32'd0);
        check_eq("midrst_op_count",  32'(op_count),  32'd0);
        exp_q.delete(); m_acc = 8'h00; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(3'd1, 1'b1, 8'hFF, 8'h5A);
        idle(4);
        check_eq("post_rst_op_count", 32'(op_count), 32'd1);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
